// File: rtl/pwm_reg_if_pkg.sv
// Shared definitions for the PWM register slave: register map, field bit
// positions and the shadow-to-active update state encoding.
package pwm_pkg;

  // Word addresses of the four registers
  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_PERIOD = 1;
  localparam int ADDR_DUTY   = 2;
  localparam int ADDR_STATUS = 3;

  // CTRL fields
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_FORCE_BIT    = 1;
  localparam int CTRL_IRQ_MASK_BIT = 2;

  // STATUS fields
  localparam int STAT_PENDING_BIT  = 0;
  localparam int STAT_PERR_BIT     = 1;
  localparam int STAT_APPLIED_BIT  = 2;

  // Shadow update tracking: PENDING means the shadow set differs from what
  // the core is running and waits for the next period boundary.
  typedef enum logic {
    UPD_IDLE    = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_e;

endpackage

// File: rtl/pwm_reg_be_merge.sv
// Byte-enable merge: each byte of the result comes from the new write data
// when its enable is set, otherwise from the old register value.
module pwm_reg_be_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_merged
);

  for (genvar b = 0; b < DATA_W/8; b++) begin : g_byte
    // one mux per byte lane
    assign o_merged[8*b +: 8] = i_be[b] ? i_wdata[8*b +: 8] : i_old[8*b +: 8];
  end

endmodule

// File: rtl/pwm_reg_if.sv
// Memory-mapped register slave feeding the PWM core. CPU writes land in
// shadow PERIOD/DUTY registers; the active pair moves only at a period
// boundary (or on force_update, or immediately while disabled) so the core
// never runs a cycle with a mixed period/duty pair.
// Optional build macro: PWM_REG_IF_IRQ_EN adds the irq output and CTRL.irq_mask.
module pwm_reg_if
  import pwm_pkg::*;
#(
  parameter int N      = 10,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic              read,
  input  logic [3:0]        byteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  input  logic              period_end,
  output logic [N-1:0]      period_out,
  output logic [N-2:0]      duty_out,
  output logic              pwm_enable
`ifdef PWM_REG_IF_IRQ_EN
  ,
  output logic              irq
`endif
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [N-1:0]      r_shadow_period;
  logic [N-2:0]      r_shadow_duty;
  logic              r_enable;
  logic              r_period_err;
  logic              r_applied;
  upd_state_e        r_state;
`ifdef PWM_REG_IF_IRQ_EN
  logic              r_irq_mask;
`endif

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic w_wr_ctrl, w_wr_period, w_wr_duty, w_wr_status;

  assign w_wr_ctrl   = write && (address == ADDR_W'(ADDR_CTRL));
  assign w_wr_period = write && (address == ADDR_W'(ADDR_PERIOD));
  assign w_wr_duty   = write && (address == ADDR_W'(ADDR_DUTY));
  assign w_wr_status = write && (address == ADDR_W'(ADDR_STATUS));

  // ---------------------------------------------------------------------
  // Byte-enable merge for the two shadow registers
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] w_per_old, w_per_merged;
  logic [DATA_W-1:0] w_duty_old, w_duty_merged;
  logic [N-1:0]      w_per_new;
  logic [N-2:0]      w_duty_new;

  assign w_per_old  = DATA_W'(r_shadow_period);
  assign w_duty_old = DATA_W'(r_shadow_duty);

  pwm_reg_be_merge #(.DATA_W(DATA_W)) u_merge_period (
    .i_old    (w_per_old),
    .i_wdata  (writedata),
    .i_be     (byteenable),
    .o_merged (w_per_merged)
  );

  pwm_reg_be_merge #(.DATA_W(DATA_W)) u_merge_duty (
    .i_old    (w_duty_old),
    .i_wdata  (writedata),
    .i_be     (byteenable),
    .o_merged (w_duty_merged)
  );

  // Bits above the register width are dropped on write
  assign w_per_new  = w_per_merged[N-1:0];
  assign w_duty_new = w_duty_merged[N-2:0];

  logic w_unused;
  assign w_unused = &{1'b0, w_per_merged[DATA_W-1:N], w_duty_merged[DATA_W-1:N-1]};

  // ---------------------------------------------------------------------
  // Update control
  // ---------------------------------------------------------------------
  logic         w_per_wr_ok;    // PERIOD write that lands in the shadow
  logic         w_per_wr_rej;   // PERIOD write that would make period 0
  logic         w_shadow_wr;    // any accepted shadow write
  logic         w_force;        // CTRL.force_update written 1
  logic         w_apply_evt;    // pre-write shadow goes active
  logic         w_apply_now;    // post-write shadow goes active (disabled)
  logic [N-1:0] w_next_period;
  logic [N-2:0] w_next_duty;

  assign w_per_wr_ok   = w_wr_period && (w_per_new != '0);
  assign w_per_wr_rej  = w_wr_period && (w_per_new == '0);
  assign w_shadow_wr   = w_per_wr_ok || w_wr_duty;
  assign w_force       = w_wr_ctrl && byteenable[0] && writedata[CTRL_FORCE_BIT];
  assign w_apply_evt   = ((r_state == UPD_PENDING) && period_end) || w_force;
  assign w_apply_now   = w_shadow_wr && !r_enable;
  assign w_next_period = w_per_wr_ok ? w_per_new  : r_shadow_period;
  assign w_next_duty   = w_wr_duty   ? w_duty_new : r_shadow_duty;

  // Shadow registers; a rejected PERIOD write leaves the shadow untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_period <= '1;
      r_shadow_duty   <= '0;
    end else begin
      r_shadow_period <= w_next_period;
      r_shadow_duty   <= w_next_duty;
    end
  end

  // Update FSM and active set. A new write in the same cycle as an apply
  // keeps the FSM in PENDING because the shadow changes again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= UPD_IDLE;
      period_out <= '1;
      duty_out   <= '0;
    end else begin
      if (w_apply_now) begin
        period_out <= w_next_period;
        duty_out   <= w_next_duty;
      end else if (w_apply_evt) begin
        period_out <= r_shadow_period;
        duty_out   <= r_shadow_duty;
      end
      case (r_state)
        UPD_IDLE: begin
          if (w_shadow_wr && r_enable)
            r_state <= UPD_PENDING;
        end
        UPD_PENDING: begin
          if (w_shadow_wr && r_enable)
            r_state <= UPD_PENDING;
          else if (w_apply_evt || w_apply_now)
            r_state <= UPD_IDLE;
        end
        default: r_state <= UPD_IDLE;
      endcase
    end
  end

  // CTRL register; force_update is a strobe and is not stored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= 1'b0;
`ifdef PWM_REG_IF_IRQ_EN
      r_irq_mask <= 1'b0;
`endif
    end else if (w_wr_ctrl && byteenable[0]) begin
      r_enable <= writedata[CTRL_ENABLE_BIT];
`ifdef PWM_REG_IF_IRQ_EN
      r_irq_mask <= writedata[CTRL_IRQ_MASK_BIT];
`endif
    end
  end

  // Sticky STATUS flags: W1C, with a new event winning over a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period_err <= 1'b0;
      r_applied    <= 1'b0;
    end else begin
      if (w_per_wr_rej)
        r_period_err <= 1'b1;
      else if (w_wr_status && byteenable[0] && writedata[STAT_PERR_BIT])
        r_period_err <= 1'b0;
      if (w_apply_evt || w_apply_now)
        r_applied <= 1'b1;
      else if (w_wr_status && byteenable[0] && writedata[STAT_APPLIED_BIT])
        r_applied <= 1'b0;
    end
  end

  // Core enable trails CTRL.enable by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_enable <= 1'b0;
    else       pwm_enable <= r_enable;
  end

`ifdef PWM_REG_IF_IRQ_EN
  // Masked interrupt, registered so it drops the cycle after the W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (r_applied | r_period_err) & r_irq_mask;
  end
`endif

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] w_rd_mux;

  // Read mux of current (pre-write) register values
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_W'(ADDR_CTRL): begin
        w_rd_mux[CTRL_ENABLE_BIT] = r_enable;
`ifdef PWM_REG_IF_IRQ_EN
        w_rd_mux[CTRL_IRQ_MASK_BIT] = r_irq_mask;
`endif
      end
      ADDR_W'(ADDR_PERIOD): w_rd_mux[N-1:0] = r_shadow_period;
      ADDR_W'(ADDR_DUTY):   w_rd_mux[N-2:0] = r_shadow_duty;
      ADDR_W'(ADDR_STATUS): begin
        w_rd_mux[STAT_PENDING_BIT] = (r_state == UPD_PENDING);
        w_rd_mux[STAT_PERR_BIT]    = r_period_err;
        w_rd_mux[STAT_APPLIED_BIT] = r_applied;
      end
      default: w_rd_mux = '0;
    endcase
  end

  // Registered read response; readdata holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= w_rd_mux;
    end
  end

endmodule

// File: tb/tb_pwm_reg_if.sv
// Directed self-checking bench for pwm_reg_if (N=10, 32-bit bus).
module tb_pwm_reg_if;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write, read;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        period_end;
  logic [9:0]  period_out;
  logic [8:0]  duty_out;
  logic        pwm_enable;
`ifdef PWM_REG_IF_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_reg_if #(.N(10), .DATA_W(32), .ADDR_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .write         (write),
    .read          (read),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .period_end    (period_end),
    .period_out    (period_out),
    .duty_out      (duty_out),
    .pwm_enable    (pwm_enable)
`ifdef PWM_REG_IF_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  // one bus write, optionally with a coincident period_end pulse
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic pe);
    address = a; writedata = d; byteenable = be; write = 1'b1; period_end = pe;
    @(posedge clk); #1;
    write = 1'b0; period_end = 1'b0; byteenable = 4'h0;
  endtask

  // one bus read; returns data and valid sampled 1 ns after the response edge
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic v);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata; v = readdatavalid;
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    @(posedge clk); #1;
    period_end = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h3FF; exp_rd[2] = 32'h0; exp_rd[3] = 32'h0;
    n_checks++; if (period_out !== 10'h3FF) begin n_fail++; $display("FAIL reset_period_out got=%h exp=3ff", period_out); end
    n_checks++; if (duty_out !== 9'h0) begin n_fail++; $display("FAIL reset_duty_out got=%h exp=0", duty_out); end
    n_checks++; if (pwm_enable !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_enable got=%b exp=0", pwm_enable); end
    n_checks++; if (readdata !== 32'h0 || readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_read got=%h/%b exp=0/0", readdata, readdatavalid); end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), d, v);
      n_checks++; if (d !== exp_rd[i] || v !== 1'b1) begin n_fail++; $display("FAIL reset_read_addr%0d got=%h/%b exp=%h/1", i, d, v, exp_rd[i]); end
    end
    @(posedge clk); #1;
    n_checks++; if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin n_fail++; $display("FAIL rdv_idle got=%h/%b exp=0/0", readdata, readdatavalid); end
  endtask

  task automatic test_deferred_apply();
    logic [31:0] d; logic v;
    bus_write(2'd0, 32'h1, 4'hF, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (pwm_enable !== 1'b1) begin n_fail++; $display("FAIL enable_on got=%b exp=1", pwm_enable); end
    bus_write(2'd2, 32'd100, 4'hF, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (duty_out !== 9'd0) begin n_fail++; $display("FAIL duty_deferred got=%0d exp=0", duty_out); end
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_pending got=%h exp=1", d); end
    pulse_pe();
    n_checks++; if (duty_out !== 9'd100) begin n_fail++; $display("FAIL duty_applied got=%0d exp=100", duty_out); end
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL status_applied got=%h exp=4", d); end
    bus_write(2'd3, 32'h4, 4'hF, 1'b0);
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL status_w1c_applied got=%h exp=0", d); end
  endtask

  task automatic test_byteenable();
    logic [31:0] d; logic v;
    bus_write(2'd1, 32'h0000_0300, 4'b0010, 1'b0);
    bus_read(2'd1, d, v);
    n_checks++; if (d !== 32'h3FF) begin n_fail++; $display("FAIL be_byte1 got=%h exp=3ff", d); end
    bus_write(2'd1, 32'h0000_0155, 4'b0001, 1'b0);
    bus_read(2'd1, d, v);
    n_checks++; if (d !== 32'h355) begin n_fail++; $display("FAIL be_byte0 got=%h exp=355", d); end
    bus_write(2'd1, 32'hFFFF_FC12, 4'b0011, 1'b0);
    bus_read(2'd1, d, v);
    n_checks++; if (d !== 32'h012) begin n_fail++; $display("FAIL be_upper_dropped got=%h exp=12", d); end
    n_checks++; if (period_out !== 10'h3FF) begin n_fail++; $display("FAIL period_deferred got=%h exp=3ff", period_out); end
    pulse_pe();
    n_checks++; if (period_out !== 10'h012 || duty_out !== 9'd100) begin n_fail++; $display("FAIL period_applied got=%h/%0d exp=12/100", period_out, duty_out); end
    bus_write(2'd3, 32'h4, 4'hF, 1'b0);
    bus_write(2'd2, 32'hFFFF_FFFF, 4'hF, 1'b0);
    bus_read(2'd2, d, v);
    n_checks++; if (d !== 32'h1FF) begin n_fail++; $display("FAIL duty_width got=%h exp=1ff", d); end
    pulse_pe();
    n_checks++; if (duty_out !== 9'h1FF || period_out !== 10'h012) begin n_fail++; $display("FAIL duty_ge_period got=%h/%h exp=1ff/12", duty_out, period_out); end
    bus_write(2'd3, 32'h4, 4'hF, 1'b0);
  endtask

  task automatic test_period_zero();
    logic [31:0] d; logic v;
    bus_write(2'd1, 32'h0, 4'hF, 1'b0);
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL perr_set got=%h exp=2", d); end
    bus_read(2'd1, d, v);
    n_checks++; if (d !== 32'h012 || period_out !== 10'h012) begin n_fail++; $display("FAIL period_zero_rejected got=%h/%h exp=12/12", d, period_out); end
    bus_write(2'd3, 32'h2, 4'hF, 1'b0);
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL perr_w1c got=%h exp=0", d); end
    // partial write whose merged result is zero is also rejected
    bus_write(2'd1, 32'hFFFF_FF00, 4'b0001, 1'b0);
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL perr_be_zero got=%h exp=2", d); end
    bus_write(2'd3, 32'h2, 4'hF, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v;
    bus_write(2'd2, 32'd50, 4'hF, 1'b0);
    bus_write(2'd2, 32'd60, 4'hF, 1'b1);
    n_checks++; if (duty_out !== 9'd50) begin n_fail++; $display("FAIL b2b_old_applied got=%0d exp=50", duty_out); end
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL b2b_still_pending got=%h exp=5", d); end
    bus_read(2'd2, d, v);
    n_checks++; if (d !== 32'd60) begin n_fail++; $display("FAIL b2b_shadow got=%0d exp=60", d); end
    pulse_pe();
    n_checks++; if (duty_out !== 9'd60) begin n_fail++; $display("FAIL b2b_new_applied got=%0d exp=60", duty_out); end
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL b2b_status got=%h exp=4", d); end
    bus_write(2'd3, 32'h4, 4'hF, 1'b0);
  endtask

  task automatic test_rw_same_and_force();
    logic [31:0] d; logic v;
    address = 2'd2; writedata = 32'd70; byteenable = 4'hF; write = 1'b1; read = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0; byteenable = 4'h0;
    n_checks++; if (readdata !== 32'd60 || readdatavalid !== 1'b1) begin n_fail++; $display("FAIL rw_same_prewrite got=%0d/%b exp=60/1", readdata, readdatavalid); end
    bus_read(2'd2, d, v);
    n_checks++; if (d !== 32'd70) begin n_fail++; $display("FAIL rw_same_postwrite got=%0d exp=70", d); end
    bus_write(2'd0, 32'h3, 4'hF, 1'b0);
    n_checks++; if (duty_out !== 9'd70) begin n_fail++; $display("FAIL force_apply got=%0d exp=70", duty_out); end
    bus_read(2'd0, d, v);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_force_reads0 got=%h exp=1", d); end
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL force_status got=%h exp=4", d); end
    bus_write(2'd3, 32'h4, 4'hF, 1'b0);
  endtask

  task automatic test_disabled_immediate();
    logic [31:0] d; logic v;
    bus_write(2'd0, 32'h0, 4'hF, 1'b0);
    bus_write(2'd1, 32'h200, 4'hF, 1'b0);
    n_checks++; if (period_out !== 10'h200) begin n_fail++; $display("FAIL disabled_period got=%h exp=200", period_out); end
    n_checks++; if (pwm_enable !== 1'b0) begin n_fail++; $display("FAIL enable_off got=%b exp=0", pwm_enable); end
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL disabled_status got=%h exp=4", d); end
    bus_write(2'd2, 32'd5, 4'hF, 1'b0);
    n_checks++; if (duty_out !== 9'd5) begin n_fail++; $display("FAIL disabled_duty got=%0d exp=5", duty_out); end
    bus_write(2'd3, 32'h4, 4'hF, 1'b0);
  endtask

`ifdef PWM_REG_IF_IRQ_EN
  task automatic test_irq();
    bus_write(2'd0, 32'h5, 4'hF, 1'b0);
    @(posedge clk); #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got=%b exp=0", irq); end
    bus_write(2'd0, 32'h7, 4'hF, 1'b0);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency got=%b exp=0", irq); end
    @(posedge clk); #1;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got=%b exp=1", irq); end
    bus_write(2'd3, 32'h4, 4'hF, 1'b0);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got=%b exp=1", irq); end
    @(posedge clk); #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", irq); end
  endtask
`endif

  task automatic test_reset_pending();
    logic [31:0] d; logic v;
    bus_write(2'd0, 32'h1, 4'hF, 1'b0);
    bus_write(2'd1, 32'h100, 4'hF, 1'b0);
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL pre_reset_pending got=%h exp=1", d); end
    reset = 1'b1; #2;
    n_checks++; if (period_out !== 10'h3FF || duty_out !== 9'h0 || pwm_enable !== 1'b0) begin n_fail++; $display("FAIL async_reset got=%h/%h/%b exp=3ff/0/0", period_out, duty_out, pwm_enable); end
    @(posedge clk); #1; reset = 1'b0;
    bus_read(2'd1, d, v);
    n_checks++; if (d !== 32'h3FF) begin n_fail++; $display("FAIL reset_discards_shadow got=%h exp=3ff", d); end
    bus_read(2'd3, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=0", d); end
  endtask

  initial begin
    reset = 1'b1; address = '0; write = 1'b0; read = 1'b0;
    byteenable = '0; writedata = '0; period_end = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_deferred_apply();
    test_byteenable();
    test_period_zero();
    test_back_to_back();
    test_rw_same_and_force();
    test_disabled_immediate();
`ifdef PWM_REG_IF_IRQ_EN
    test_irq();
`endif
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_reg_if.md
Name: pwm_reg_if

Overview:
- Memory-mapped register slave that sits directly upstream of the PWM core.
- Accepts CPU writes and reads of the PWM period, duty cycle and control over a simple word bus with per-byte enables.
- Writes land in shadow registers and move to the active outputs only at a PWM period boundary, so every PWM cycle runs with one consistent period/duty pair.

Parameters:
- N, 10, PWM counter width; period output is N bits, duty output is N-1 bits.
- DATA_W, 32, bus data width; must be 32.
- ADDR_W, 2, word address width; 4 registers.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  ADDR_W  word address of access.
- write  input  1  write strobe, one-cycle qualified.
- read  input  1  read strobe, one-cycle qualified.
- byteenable  input  4  per-byte write enables.
- writedata  input  32  write data.
- readdata  output  32  read data; valid when readdatavalid=1.
- readdatavalid  output  1  one-cycle pulse, exactly 1 cycle after an accepted read.
- period_end  input  1  one-cycle pulse from the PWM core when its counter wraps.
- period_out  output  N  active period to the core.
- duty_out  output  N-1  active duty cycle to the core.
- pwm_enable  output  1  active enable; when 0 the core output is forced low downstream.

Behaviour:
- Register map, word addresses:
  - 0 CTRL: bit0 enable; bit1 force_update, write-1 self-clearing, reads 0.
  - 1 PERIOD: bits N-1:0 are the shadow period.
  - 2 DUTY: bits N-2:0 are the shadow duty.
  - 3 STATUS: bit0 pending, RO; bit1 period_err, sticky, write-1-to-clear; bit2 applied, sticky, W1C.
- Byte enables: each byte of the target register updates only if its byteenable bit is set. Bits above the register width are ignored on write and read 0.
- Reads:
  - Registered, latency 1: readdata and readdatavalid update the cycle after read=1.
  - readdata returns the shadow value for PERIOD and DUTY, not the active value.
  - With read=0, readdatavalid=0 and readdata holds its last value.
  - Simultaneous read and write to the same address returns the pre-write value.
- Shadow write rules:
  - A write to PERIOD or DUTY sets pending=1.
  - A PERIOD write whose resulting shadow value is 0 is rejected: shadow keeps its old value, period_err=1, pending is unaffected.
- Apply rules:
  - The active set (period_out, duty_out) copies the shadow set when pending=1 and period_end=1, or when force_update is written 1.
  - On apply: pending=0, applied=1.
  - period_end together with a PERIOD/DUTY write in the same cycle: the pre-write shadow is applied and pending stays 1 because of the new write.
- While enable=0, every PERIOD/DUTY write applies immediately, without waiting for period_end.
- pwm_enable follows CTRL.enable with 1-cycle latency. Enable changes are not deferred.
- duty ≥ period is legal (100% duty); no clamping.
- Update state machine:
  - IDLE → PENDING on an accepted shadow write while enabled.
  - PENDING → IDLE on apply.
  - Reset in PENDING discards the shadow.
- Reset values:
  - shadow and active period = 2^N-1; shadow and active duty = 0.
  - enable=0, all STATUS bits 0.
  - readdata=0, readdatavalid=0.

Optional Feature:
- Macro PWM_REG_IF_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and CTRL bit2 irq_mask, reset 0.
  - irq = (applied | period_err) & irq_mask, registered with 1-cycle latency.
  - irq deasserts the cycle after the W1C that clears the cause.
- Undefined:
  - No irq port exists.
  - CTRL bit2 reads 0 and ignores writes.

Decomposition:
- Shared package pwm_pkg holds:
  - Register address constants: ADDR_CTRL=0, ADDR_PERIOD=1, ADDR_DUTY=2, ADDR_STATUS=3.
  - Bit-position constants for the CTRL and STATUS fields.
  - Update-state enum (IDLE, PENDING).
- One natural sub-module, pwm_reg_be_merge: combinational byte-enable merge of writedata into the old register value. It is instantiated for PERIOD and DUTY.

Test Plan:
- Reset, then read all 4 addresses → 0x0, 0x3FF, 0x0, 0x0 (N=10); readdatavalid 1 cycle after each read.
- enable=1, write DUTY=100, no period_end → duty_out stays 0, STATUS=0x1; pulse period_end → duty_out=100 next cycle, STATUS=0x4.
- Write PERIOD=0x0000_0300 with byteenable=4'b0010 over old 0x3FF → shadow PERIOD=0x3FF, since bits 9:8 only come from byte 1 = 0x03.
- Write PERIOD=0 → period_out unchanged, STATUS bit1=1; write STATUS=0x2 → bit1 clears.
- Write DUTY in the same cycle as period_end while already pending → old shadow applied, pending remains 1, new value applied at the next period_end.
- With PWM_REG_IF_IRQ_EN: set irq_mask, force_update → irq=1 one cycle after apply; write STATUS=0x4 → irq=0 the next cycle.
